char_anim_fsm: RTL

Parametrised per-character animation/action sequencer that supersedes the fixed-table fighter FSMs. It arbitrates player action requests into one of eight action states and steps a sprite frame index at a per-state rate derived from frame_clk. It also buffers one attack request, blocks hits while defending, emits hit and completion pulses, and rearms on game restart. One instance per fighter; it sits between the input/collision logic and the sprite ROM address generator.

---
 rtl/char_anim_fsm.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/char_anim_fsm.sv
// Per-character action sequencer and sprite frame stepper.
// Action requests are arbitrated into one of eight states on each frame tick.
// The frame index advances at a per-state rate. One attack request can be buffered.
// Hit, blocked and completion pulses are registered and last one Clk.
// The current state is visible on state_out and on the registered one-hot decode.
module char_anim_fsm #(
    parameter int                  FRAME_W         = 8,
    parameter int                  DLY_W           = 8,
    parameter logic [7:0]          GAME_PLAY       = 8'd1,
    parameter logic [FRAME_W-1:0]  FRAMES_STAND    = 8,
    parameter logic [FRAME_W-1:0]  FRAMES_MOVE     = 9,
    parameter logic [FRAME_W-1:0]  FRAMES_ATTACK   = 6,
    parameter logic [FRAME_W-1:0]  FRAMES_DEFENSE  = 1,
    parameter logic [FRAME_W-1:0]  FRAMES_HURT     = 5,
    parameter logic [FRAME_W-1:0]  FRAMES_JUMP     = 8,
    parameter logic [FRAME_W-1:0]  FRAMES_DIE      = 5,
    parameter logic [DLY_W-1:0]    DELAY_STAND     = 8,
    parameter logic [DLY_W-1:0]    DELAY_MOVE      = 6,
    parameter logic [DLY_W-1:0]    DELAY_ATTACK    = 3,
    parameter logic [DLY_W-1:0]    DELAY_DEFENSE   = 8,
    parameter logic [DLY_W-1:0]    DELAY_HURT      = 3,
    parameter logic [DLY_W-1:0]    DELAY_JUMP      = 4,
    parameter logic [DLY_W-1:0]    DELAY_DIE       = 3,
    parameter logic [FRAME_W-1:0]  HIT_FRAME       = 3
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic               enable,
    input  logic [7:0]         game_state,
    input  logic               req_attack,
    input  logic               req_move_l,
    input  logic               req_move_r,
    input  logic               req_defense,
    input  logic               req_jump,
    input  logic               ev_hurt,
    input  logic               ev_die,
    output logic [7:0]         state_out,
    output logic [FRAME_W-1:0] frame_num,
    output logic               stand,
    output logic               attack,
    output logic               move_l,
    output logic               move_r,
    output logic               defense,
    output logic               hurt,
    output logic               jump,
    output logic               die,
    output logic               hit_pulse,
    output logic               blocked_pulse,
    output logic               anim_done
);

    typedef enum logic [7:0] {
        ST_STAND   = 8'd0,
        ST_ATTACK  = 8'd1,
        ST_MOVE_L  = 8'd2,
        ST_MOVE_R  = 8'd3,
        ST_DEFENSE = 8'd4,
        ST_HURT    = 8'd5,
        ST_DIE     = 8'd6,
        ST_JUMP    = 8'd7
    } state_t;

    state_t             state, nxt_state, chosen;
    logic [DLY_W-1:0]   delay, nxt_delay, cur_dly;
    logic [FRAME_W-1:0] nxt_frame, cur_last, step_frame;
    logic               attack_pending, nxt_pend;
    logic               nxt_hit, nxt_blk, nxt_done;
    logic               dly_done, at_last;
    logic [7:0]         nxt_onehot;

    logic fc_s1, fc_s2, fc_s3, tick_r, tick_en;
    logic play_q, in_play, restart;

    // Bring frame_clk into the Clk domain and turn each rising edge into a one-cycle tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fc_s1  <= 1'b0;
            fc_s2  <= 1'b0;
            fc_s3  <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            fc_s1  <= frame_clk;
            fc_s2  <= fc_s1;
            fc_s3  <= fc_s2;
            tick_r <= fc_s2 & ~fc_s3;
        end
    end

    // Remember the previous "in play" level so entry into play can be detected.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) play_q <= 1'b0;
        else          play_q <= in_play;
    end

    assign in_play = (game_state == GAME_PLAY);
    assign restart = in_play & ~play_q;
    assign tick_en = tick_r & enable;

    // Per-state animation length and frame duration.
    always_comb begin
        cur_last = '0;
        cur_dly  = '0;
        case (state)
            ST_STAND:   begin cur_last = FRAMES_STAND - 1'b1;   cur_dly = DELAY_STAND;   end
            ST_ATTACK:  begin cur_last = FRAMES_ATTACK - 1'b1;  cur_dly = DELAY_ATTACK;  end
            ST_MOVE_L,
            ST_MOVE_R:  begin cur_last = FRAMES_MOVE - 1'b1;    cur_dly = DELAY_MOVE;    end
            ST_DEFENSE: begin cur_last = FRAMES_DEFENSE - 1'b1; cur_dly = DELAY_DEFENSE; end
            ST_HURT:    begin cur_last = FRAMES_HURT - 1'b1;    cur_dly = DELAY_HURT;    end
            ST_DIE:     begin cur_last = FRAMES_DIE - 1'b1;     cur_dly = DELAY_DIE;     end
            ST_JUMP:    begin cur_last = FRAMES_JUMP - 1'b1;    cur_dly = DELAY_JUMP;    end
            default:    begin cur_last = '0;                    cur_dly = '0;            end
        endcase
    end

    // Request arbitration for the free-roaming states: attack > jump > move_r > move_l > defense.
    always_comb begin
        chosen = ST_STAND;
        if (req_attack)       chosen = ST_ATTACK;
        else if (req_jump)    chosen = ST_JUMP;
        else if (req_move_r)  chosen = ST_MOVE_R;
        else if (req_move_l)  chosen = ST_MOVE_L;
        else if (req_defense) chosen = ST_DEFENSE;
    end

    // >= comparisons let out-of-range counters recover on the next advance.
    assign dly_done   = (delay >= cur_dly);
    assign at_last    = (frame_num >= cur_last);
    assign step_frame = at_last ? '0 : frame_num + FRAME_W'(1);

    // Next-state, frame/delay stepping, pending attack and pulse generation.
    always_comb begin
        nxt_state = state;
        nxt_frame = frame_num;
        nxt_delay = delay;
        nxt_pend  = attack_pending;
        nxt_hit   = 1'b0;
        nxt_blk   = 1'b0;
        nxt_done  = 1'b0;
        if (tick_en) begin
            // Buffer one attack request while busy with a one-shot animation.
            if (req_attack && ((state == ST_ATTACK && frame_num != '0) ||
                               state == ST_HURT || state == ST_JUMP))
                nxt_pend = 1'b1;

            if (ev_die && state != ST_DIE) begin
                nxt_state = ST_DIE;
                nxt_frame = '0;
                nxt_delay = '0;
                nxt_pend  = 1'b0;
            end else if (ev_hurt && state != ST_DIE && state != ST_JUMP) begin
                if (state == ST_DEFENSE) begin
                    // Blocked hit: keep defending and keep animating.
                    nxt_blk = 1'b1;
                    if (!dly_done) nxt_delay = delay + DLY_W'(1);
                    else begin
                        nxt_delay = '0;
                        nxt_frame = step_frame;
                    end
                end else begin
                    nxt_state = ST_HURT;
                    nxt_frame = '0;
                    nxt_delay = '0;
                end
            end else begin
                case (state)
                    ST_STAND, ST_MOVE_L, ST_MOVE_R: begin
                        if (chosen != state) begin
                            nxt_state = chosen;
                            nxt_frame = '0;
                            nxt_delay = '0;
                            if (chosen == ST_ATTACK) nxt_pend = 1'b0;
                        end else if (!dly_done) begin
                            nxt_delay = delay + DLY_W'(1);
                        end else begin
                            nxt_delay = '0;
                            nxt_frame = step_frame;
                        end
                    end
                    ST_DEFENSE: begin
                        if (!req_defense) begin
                            nxt_state = ST_STAND;
                            nxt_frame = '0;
                            nxt_delay = '0;
                        end else if (!dly_done) begin
                            nxt_delay = delay + DLY_W'(1);
                        end else begin
                            nxt_delay = '0;
                            nxt_frame = step_frame;
                        end
                    end
                    ST_ATTACK, ST_HURT, ST_JUMP: begin
                        if (dly_done && at_last) begin
                            nxt_done  = 1'b1;
                            nxt_frame = '0;
                            nxt_delay = '0;
                            if (nxt_pend || req_attack) begin
                                nxt_state = ST_ATTACK;
                                nxt_pend  = 1'b0;
                            end else begin
                                nxt_state = ST_STAND;
                            end
                        end else if (!dly_done) begin
                            nxt_delay = delay + DLY_W'(1);
                        end else begin
                            nxt_delay = '0;
                            nxt_frame = step_frame;
                            if (state == ST_ATTACK && step_frame == HIT_FRAME)
                                nxt_hit = 1'b1;
                        end
                    end
                    ST_DIE: begin
                        // Step to the final frame and hold it there.
                        if (!dly_done) begin
                            nxt_delay = delay + DLY_W'(1);
                        end else begin
                            nxt_delay = '0;
                            nxt_frame = at_last ? cur_last : frame_num + FRAME_W'(1);
                        end
                    end
                    default: begin
                        nxt_state = ST_STAND;
                        nxt_frame = '0;
                        nxt_delay = '0;
                    end
                endcase
            end
        end
    end

    assign nxt_onehot = 8'b1 << nxt_state[2:0];

    // State, counters and registered outputs; restart overrides enable and tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= ST_STAND;
            frame_num      <= '0;
            delay          <= '0;
            attack_pending <= 1'b0;
            {jump, die, hurt, defense, move_r, move_l, attack, stand} <= 8'b0000_0001;
            hit_pulse      <= 1'b0;
            blocked_pulse  <= 1'b0;
            anim_done      <= 1'b0;
        end else if (restart) begin
            state          <= ST_STAND;
            frame_num      <= '0;
            delay          <= '0;
            attack_pending <= 1'b0;
            {jump, die, hurt, defense, move_r, move_l, attack, stand} <= 8'b0000_0001;
            hit_pulse      <= 1'b0;
            blocked_pulse  <= 1'b0;
            anim_done      <= 1'b0;
        end else if (enable) begin
            state          <= nxt_state;
            frame_num      <= nxt_frame;
            delay          <= nxt_delay;
            attack_pending <= nxt_pend;
            {jump, die, hurt, defense, move_r, move_l, attack, stand} <= nxt_onehot;
            hit_pulse      <= nxt_hit;
            blocked_pulse  <= nxt_blk;
            anim_done      <= nxt_done;
        end else begin
            hit_pulse      <= 1'b0;
            blocked_pulse  <= 1'b0;
            anim_done      <= 1'b0;
        end
    end

    assign state_out = state;

endmodule
